// File: rtl/ch_spi_readout_gen2.sv
`default_nettype none
// =============================================================================
// Module  : ch_spi_readout_gen2
// Brief   : Snapshots NUM_CH hit counters plus trigger count into a zero-padded
//           frame and shifts one byte (or byte..end) MSB-first on CNT_SER.
//           Optional macro CH_READOUT_PARITY_EN appends an even-parity bit/byte.
// Revision: 1.0 - initial release
// =============================================================================
module ch_spi_readout_gen2 #(
  parameter  int NUM_CH    = 5,
  parameter  int CNT_W     = 10,
  parameter  int TRIG_W    = 3,
  parameter  int BYTE_W    = 8,
  localparam int DATA_W    = TRIG_W + NUM_CH*CNT_W,
  localparam int NUM_BYTES = (DATA_W + BYTE_W - 1) / BYTE_W,
  localparam int FRAME_W   = BYTE_W*NUM_BYTES,
  localparam int SEL_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                    SPI_CLK,
  input  logic                    RST,
  input  logic                    INST_READOUT,
  input  logic [SEL_W-1:0]        SELECT_REG,
  input  logic                    AUTO_INC,
  input  logic [TRIG_W-1:0]       trigger_cnt,
  input  logic [NUM_CH*CNT_W-1:0] CNT,
  output logic                    CNT_SER,
  output logic                    BYTE_DONE,
  output logic                    FRAME_DONE,
  output logic                    BUSY,
  output logic                    SEL_ERR
);

  localparam int BIT_W  = $clog2(BYTE_W + 1);
  localparam int IDX_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int SELP_W = SEL_W + 1;

  localparam logic [0:0]        c_st_idle   = 1'b0;
  localparam logic [0:0]        c_st_shift  = 1'b1;
  localparam logic [IDX_W-1:0]  c_msb_idx   = IDX_W'(BYTE_W - 1);
  localparam logic [SELP_W-1:0] c_num_bytes = SELP_W'(NUM_BYTES);
  localparam logic [SEL_W-1:0]  c_last_byte = SEL_W'(NUM_BYTES - 1);
`ifdef CH_READOUT_PARITY_EN
  localparam logic [BIT_W-1:0]  c_last_pos  = BIT_W'(BYTE_W);
`else
  localparam logic [BIT_W-1:0]  c_last_pos  = BIT_W'(BYTE_W - 1);
`endif

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               r_inst_q;
  logic               r_auto_inc;
  logic [FRAME_W-1:0] r_snap;
  logic [SEL_W-1:0]   r_byte_idx;
  logic [BIT_W-1:0]   r_bit_pos;
  logic               r_ser;
  logic               r_byte_done;
  logic               r_frame_done;
  logic               r_sel_err;

  logic [FRAME_W-1:0] w_frame;
  logic [BYTE_W-1:0]  w_bytes [NUM_BYTES];
  logic [BYTE_W-1:0]  w_cur_byte;
  logic [IDX_W-1:0]   w_bit_idx;
  logic               w_out_bit;
  logic               w_trig;
  logic               w_sel_ok;
  logic               w_last_bit;
  logic               w_last_byte;
  logic               w_busy;

  // Counters occupy the low bits, trigger count above them, zero pad on top.
  assign w_frame = FRAME_W'({trigger_cnt, CNT});

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bytes
    assign w_bytes[g] = r_snap[g*BYTE_W +: BYTE_W];
  end

  assign w_cur_byte  = w_bytes[r_byte_idx];
  assign w_bit_idx   = c_msb_idx - r_bit_pos[IDX_W-1:0];
  assign w_trig      = INST_READOUT & ~r_inst_q & (r_state == c_st_idle);
  assign w_sel_ok    = {1'b0, SELECT_REG} < c_num_bytes;
  assign w_last_bit  = (r_bit_pos == c_last_pos);
  assign w_last_byte = (r_byte_idx == c_last_byte);

`ifdef CH_READOUT_PARITY_EN
  assign w_out_bit = w_last_bit ? (^w_cur_byte) : w_cur_byte[w_bit_idx];
`else
  assign w_out_bit = w_cur_byte[w_bit_idx];
`endif

  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_trig && w_sel_ok) begin
          w_state_nxt = c_st_shift;
        end
      end
      c_st_shift: begin
        if (w_last_bit && (!r_auto_inc || w_last_byte)) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_st_shift);
  end

  // AUTO_INC and SELECT_REG are only looked at on the trigger cycle.
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      r_inst_q     <= 1'b0;
      r_auto_inc   <= 1'b0;
      r_snap       <= '0;
      r_byte_idx   <= '0;
      r_bit_pos    <= '0;
      r_ser        <= 1'b0;
      r_byte_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_inst_q     <= INST_READOUT;
      r_byte_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sel_err    <= 1'b0;
      if (r_state == c_st_idle) begin
        r_ser <= 1'b0;
        if (w_trig) begin
          if (w_sel_ok) begin
            r_snap     <= w_frame;
            r_byte_idx <= SELECT_REG;
            r_bit_pos  <= '0;
            r_auto_inc <= AUTO_INC;
          end else begin
            r_sel_err  <= 1'b1;
          end
        end
      end else begin
        r_ser <= w_out_bit;
        if (w_last_bit) begin
          r_bit_pos   <= '0;
          r_byte_done <= 1'b1;
          if (r_auto_inc && !w_last_byte) begin
            r_byte_idx <= r_byte_idx + 1'b1;
          end
          if (r_auto_inc && w_last_byte) begin
            r_frame_done <= 1'b1;
          end
        end else begin
          r_bit_pos <= r_bit_pos + 1'b1;
        end
      end
    end
  end

  assign CNT_SER    = r_ser;
  assign BYTE_DONE  = r_byte_done;
  assign FRAME_DONE = r_frame_done;
  assign BUSY       = w_busy;
  assign SEL_ERR    = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_ch_spi_readout_gen2.sv
`default_nettype none
// =============================================================================
// Module  : tb_ch_spi_readout_gen2
// Brief   : Randomized self-checking bench for ch_spi_readout_gen2 against a
//           bit-stream reference model. Honours CH_READOUT_PARITY_EN.
// Revision: 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_ch_spi_readout_gen2;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 10;
  localparam int TRIG_W = 3;
  localparam int BYTE_W = 8;
  localparam int CW     = NUM_CH*CNT_W;
  localparam int NB     = (TRIG_W + CW + BYTE_W - 1) / BYTE_W;
  localparam int SEL_W  = 3;
`ifdef CH_READOUT_PARITY_EN
  localparam int CPB = BYTE_W + 1;
`else
  localparam int CPB = BYTE_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              inst;
  logic [SEL_W-1:0]  sel;
  logic              auto_inc;
  logic [TRIG_W-1:0] trig;
  logic [CW-1:0]     cnt;
  logic              ser, bd, fd, busy, serr;

  int total = 0;
  int bad   = 0;

  logic [127:0] obs_ser, obs_bd, obs_fd, obs_busy, obs_err;
  logic [127:0] exp_ser, exp_bd, exp_fd, exp_busy, exp_err;

  ch_spi_readout_gen2 dut (
    .SPI_CLK     (clk),
    .RST         (rst),
    .INST_READOUT(inst),
    .SELECT_REG  (sel),
    .AUTO_INC    (auto_inc),
    .trigger_cnt (trig),
    .CNT         (cnt),
    .CNT_SER     (ser),
    .BYTE_DONE   (bd),
    .FRAME_DONE  (fd),
    .BUSY        (busy),
    .SEL_ERR     (serr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_frame(input logic [TRIG_W-1:0] t, input logic [CW-1:0] c);
    logic [63:0] f;
    f = 64'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      f = f + (64'(c[k*CNT_W +: CNT_W]) << (k*CNT_W));
    end
    f = f + (64'(t) << CW);
    return f;
  endfunction

  function automatic int xfer_len(input int s, input bit a);
    if (s >= NB) return 0;
    return (a ? (NB - s) : 1) * CPB;
  endfunction

  // Index 0 is the cycle right after the trigger edge; index k>=1 carries bit k.
  task automatic build_exp(input logic [63:0] f, input int s, input bit a, input int ncap);
    int len, bpos, byt;
    logic p;
    exp_ser = '0; exp_bd = '0; exp_fd = '0; exp_busy = '0; exp_err = '0;
    if (s >= NB) begin
      exp_err[0] = 1'b1;
      return;
    end
    len = xfer_len(s, a);
    for (int k = 0; k < ncap; k++) begin
      if (k == 0) begin
        exp_busy[k] = 1'b1;
      end else if (k <= len) begin
        bpos = (k - 1) % CPB;
        byt  = s + (k - 1) / CPB;
        if (bpos < BYTE_W) begin
          exp_ser[k] = f[byt*BYTE_W + BYTE_W - 1 - bpos];
        end else begin
          p = 1'b0;
          for (int j = 0; j < BYTE_W; j++) p = p ^ f[byt*BYTE_W + j];
          exp_ser[k] = p;
        end
        exp_busy[k] = (k < len);
        exp_bd[k]   = (bpos == CPB - 1);
        exp_fd[k]   = a && (k == len);
      end
    end
  endtask

  task automatic fire(input int s, input bit a);
    sel      = SEL_W'(s);
    auto_inc = a;
    inst     = 1'b1;
  endtask

  task automatic capture(input int ncap, input bit disturb, input int quiet_from);
    obs_ser = '0; obs_bd = '0; obs_fd = '0; obs_busy = '0; obs_err = '0;
    for (int i = 0; i < ncap; i++) begin
      step();
      obs_ser[i] = ser; obs_bd[i] = bd; obs_fd[i] = fd; obs_busy[i] = busy; obs_err[i] = serr;
      if (disturb && i < quiet_from) begin
        cnt      = CW'({$urandom(), $urandom()});
        trig     = TRIG_W'($urandom());
        inst     = 1'($urandom_range(0, 1));
        sel      = SEL_W'($urandom());
        auto_inc = 1'($urandom_range(0, 1));
      end else begin
        inst = 1'b0;
      end
    end
  endtask

  task automatic rand_data();
    cnt  = CW'({$urandom(), $urandom()});
    trig = TRIG_W'($urandom());
  endtask

  task automatic test_reset();
    rst = 1'b1; inst = 1'b0; sel = '0; auto_inc = 1'b0; trig = '0; cnt = '0;
    repeat (3) step();
    total++;
    if ({ser, bd, fd, busy, serr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold outputs got=%b exp=00000", {ser, bd, fd, busy, serr});
    end
    rst = 1'b0;
    repeat (3) step();
    total++;
    if ({ser, bd, fd, busy, serr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_release outputs got=%b exp=00000", {ser, bd, fd, busy, serr});
    end
  endtask

  task automatic test_single_byte();
    for (int t = 0; t < 9; t++) begin
      int s;
      if (t < 3) begin
        cnt = '0; cnt[CNT_W-1:0] = '1; trig = 3'b101;
        s = (t == 0) ? 0 : ((t == 1) ? 1 : 6);
      end else begin
        rand_data();
        s = $urandom_range(0, NB - 1);
      end
      build_exp(mk_frame(trig, cnt), s, 1'b0, CPB + 3);
      fire(s, 1'b0);
      capture(CPB + 3, 1'b0, 0);
      total++;
      if (obs_ser !== exp_ser) begin
        bad++;
        $display("FAIL single sel=%0d ser got=%h exp=%h", s, obs_ser, exp_ser);
      end
      total++;
      if ({obs_bd, obs_fd, obs_busy, obs_err} !== {exp_bd, exp_fd, exp_busy, exp_err}) begin
        bad++;
        $display("FAIL single sel=%0d flags bd=%h/%h fd=%h/%h busy=%h/%h (got/exp)",
                 s, obs_bd, exp_bd, obs_fd, exp_fd, obs_busy, exp_busy);
      end
      if (t == 0 || t == 2) begin
        total++;
        if (obs_ser[8:1] !== ((t == 0) ? 8'b11111111 : 8'b00101000)) begin
          bad++;
          $display("FAIL single_literal sel=%0d bits got=%b", s, obs_ser[8:1]);
        end
      end
    end
  endtask

  task automatic test_auto_inc();
    for (int t = 0; t < 4; t++) begin
      int s, len;
      if (t == 0) begin
        cnt = '0; cnt[CNT_W-1:0] = '1; trig = 3'b101; s = 5;
      end else begin
        rand_data();
        s = $urandom_range(0, NB - 1);
      end
      len = xfer_len(s, 1'b1);
      build_exp(mk_frame(trig, cnt), s, 1'b1, len + 3);
      fire(s, 1'b1);
      capture(len + 3, 1'b0, 0);
      total++;
      if (obs_ser !== exp_ser) begin
        bad++;
        $display("FAIL auto sel=%0d ser got=%h exp=%h", s, obs_ser, exp_ser);
      end
      total++;
      if ({obs_bd, obs_fd, obs_busy, obs_err} !== {exp_bd, exp_fd, exp_busy, exp_err}) begin
        bad++;
        $display("FAIL auto sel=%0d flags bd=%h/%h fd=%h/%h busy=%h/%h (got/exp)",
                 s, obs_bd, exp_bd, obs_fd, exp_fd, obs_busy, exp_busy);
      end
    end
  endtask

  task automatic test_sel_err();
    rand_data();
    build_exp(mk_frame(trig, cnt), 7, 1'($urandom_range(0, 1)), 5);
    fire(7, 1'($urandom_range(0, 1)));
    capture(5, 1'b0, 0);
    total++;
    if ({obs_ser, obs_bd, obs_fd, obs_busy, obs_err} !== {exp_ser, exp_bd, exp_fd, exp_busy, exp_err}) begin
      bad++;
      $display("FAIL sel_err err=%h/%h busy=%h/%h ser=%h/%h (got/exp)",
               obs_err, exp_err, obs_busy, exp_busy, obs_ser, exp_ser);
    end
  endtask

  task automatic test_freeze();
    for (int t = 0; t < 3; t++) begin
      int s, len;
      bit a;
      rand_data();
      s   = $urandom_range(0, NB - 1);
      a   = 1'($urandom_range(0, 1));
      len = xfer_len(s, a);
      build_exp(mk_frame(trig, cnt), s, a, len + 3);
      fire(s, a);
      capture(len + 3, 1'b1, len - 2);
      total++;
      if ({obs_ser, obs_bd, obs_fd, obs_busy} !== {exp_ser, exp_bd, exp_fd, exp_busy}) begin
        bad++;
        $display("FAIL freeze sel=%0d ser=%h/%h busy=%h/%h (got/exp)",
                 s, obs_ser, exp_ser, obs_busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic seen_bd;
    cnt = '0; cnt[CNT_W-1:0] = '1; trig = 3'b101;
    fire(0, 1'b1);
    capture(4, 1'b0, 0);
    rst = 1'b1;
    #1;
    total++;
    if ({ser, bd, fd, busy, serr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid immediate outputs got=%b exp=00000", {ser, bd, fd, busy, serr});
    end
    step();
    #1 rst = 1'b0;
    seen_bd = 1'b0;
    for (int i = 0; i < 2*CPB; i++) begin
      step();
      seen_bd = seen_bd | bd | fd | busy | ser;
    end
    total++;
    if (seen_bd !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid activity after abort got=%b exp=0", seen_bd);
    end
    rand_data();
    s = $urandom_range(0, NB - 1);
    build_exp(mk_frame(trig, cnt), s, 1'b0, CPB + 3);
    fire(s, 1'b0);
    capture(CPB + 3, 1'b0, 0);
    total++;
    if ({obs_ser, obs_bd, obs_busy} !== {exp_ser, exp_bd, exp_busy}) begin
      bad++;
      $display("FAIL reset_mid fresh sel=%0d ser=%h/%h bd=%h/%h (got/exp)",
               s, obs_ser, exp_ser, obs_bd, exp_bd);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      int s, len;
      bit a;
      rand_data();
      s   = $urandom_range(0, NB - 1);
      a   = 1'($urandom_range(0, 1));
      len = xfer_len(s, a);
      // Capture stops on the final-bit cycle so the next trigger lands one cycle later.
      build_exp(mk_frame(trig, cnt), s, a, len + 1);
      fire(s, a);
      capture(len + 1, 1'b0, 0);
      total++;
      if ({obs_ser, obs_bd, obs_fd, obs_busy} !== {exp_ser, exp_bd, exp_fd, exp_busy}) begin
        bad++;
        $display("FAIL b2b_first sel=%0d ser=%h/%h busy=%h/%h (got/exp)",
                 s, obs_ser, exp_ser, obs_busy, exp_busy);
      end
      rand_data();
      s   = $urandom_range(0, NB - 1);
      a   = 1'($urandom_range(0, 1));
      len = xfer_len(s, a);
      build_exp(mk_frame(trig, cnt), s, a, len + 3);
      fire(s, a);
      capture(len + 3, 1'b0, 0);
      total++;
      if ({obs_ser, obs_bd, obs_fd, obs_busy} !== {exp_ser, exp_bd, exp_fd, exp_busy}) begin
        bad++;
        $display("FAIL b2b_second sel=%0d ser=%h/%h busy=%h/%h (got/exp)",
                 s, obs_ser, exp_ser, obs_busy, exp_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_auto_inc();
    test_sel_err();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ch_spi_readout_gen2.md
Name: ch_spi_readout_gen2

Overview:
Parametrised successor to the per-channel counter SPI readout serializer. On an INST_READOUT rising edge it snapshots NUM_CH hit counters plus the trigger count into one zero-padded frame. It then shifts one selected byte, or every byte from the selected one to the end of the frame, MSB-first on CNT_SER. The block sits in the channel digital block, clocked by SPI_CLK, feeding the chip SPI MISO mux.

Parameters:
NUM_CH, 5, number of channel counters in the frame
CNT_W, 10, width of each channel counter
TRIG_W, 3, width of trigger_cnt
BYTE_W, 8, serialized unit width; frame padded to a multiple of BYTE_W
(derived) FRAME_W = BYTE_W*NUM_BYTES; NUM_BYTES = ceil((TRIG_W+NUM_CH*CNT_W)/BYTE_W), 7 by default
(derived) SEL_W = max(1, clog2(NUM_BYTES)), 3 by default

Ports:
SPI_CLK  in  1  sole clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
INST_READOUT  in  1  level; rising edge detected synchronously in SPI_CLK domain
SELECT_REG  in  SEL_W  starting byte index
AUTO_INC  in  1  0 = single byte, 1 = stream from SELECT_REG to last byte
trigger_cnt  in  TRIG_W  trigger count to capture
CNT  in  NUM_CH*CNT_W  channel counters, CNT[k] = bits [k*CNT_W +: CNT_W]
CNT_SER  out  1  serial data, MSB of byte first
BYTE_DONE  out  1  high in the same cycle as the last bit of each byte
FRAME_DONE  out  1  high with the last bit of byte NUM_BYTES-1, AUTO_INC mode only
BUSY  out  1  high while state = SHIFT
SEL_ERR  out  1  one-cycle pulse when SELECT_REG >= NUM_BYTES at a trigger

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; snapshot, bit_pos, byte_idx and the inst_q edge register cleared.
  - CNT_SER, BYTE_DONE, FRAME_DONE, BUSY and SEL_ERR all 0.
  - Reset mid-shift aborts the transfer; no done pulses are emitted.
- Frame layout: {zero pad, trigger_cnt, CNT[NUM_CH-1], ..., CNT[0]}, with CNT[0] at bit 0. Byte k = frame[k*BYTE_W +: BYTE_W].
- Trigger: inst_q registers INST_READOUT every cycle. Trigger = INST_READOUT & ~inst_q & (state == IDLE).
- IDLE:
  - On trigger with a valid SELECT_REG: at edge n, snapshot <= frame, byte_idx <= SELECT_REG, bit_pos <= 0, state <= SHIFT.
  - On trigger with SELECT_REG >= NUM_BYTES: SEL_ERR pulses for one cycle after edge n; state stays IDLE.
  - CNT_SER is held 0 in IDLE.
- SHIFT (one bit per cycle):
  - Each edge: CNT_SER <= snapshot[byte_idx*BYTE_W + BYTE_W-1-bit_pos]; bit_pos increments.
  - First bit is on CNT_SER after edge n+1; last bit of the first byte after edge n+BYTE_W.
  - On the edge that drives the last bit: BYTE_DONE <= 1 for one cycle and bit_pos <= 0.
    - AUTO_INC = 0: state <= IDLE.
    - AUTO_INC = 1 and byte_idx < NUM_BYTES-1: byte_idx increments; shifting continues without a gap.
    - AUTO_INC = 1 and byte_idx = NUM_BYTES-1: FRAME_DONE <= 1 as well; state <= IDLE.
  - AUTO_INC and SELECT_REG are sampled only at the trigger. Changes during SHIFT are ignored.
- INST_READOUT edges during SHIFT are ignored; the snapshot stays frozen. A new trigger needs INST_READOUT low for at least one cycle while IDLE, then high.
- BUSY is high after edges n..(last-bit edge - 1). It is low during the cycle the final bit is on the line.
- Back-to-back operation: a trigger arriving in the cycle right after IDLE is re-entered is accepted.

Optional Feature:
Macro CH_READOUT_PARITY_EN.
- Defined: each byte is followed by one even-parity bit (XOR of the byte's BYTE_W bits), so each byte takes BYTE_W+1 cycles. BYTE_DONE and FRAME_DONE align with the parity bit, not the last data bit.
- Undefined: no parity bit; BYTE_W cycles per byte. Port list is identical in both builds.

Test Plan:
1. Defaults; CNT[0]=10'h3FF, other counters 0, trigger_cnt=3'b101, SELECT_REG=0, AUTO_INC=0; INST_READOUT 0->1 -> CNT_SER = 1,1,1,1,1,1,1,1 on cycles n+1..n+8; BYTE_DONE at n+8; FRAME_DONE stays 0.
2. Same data, SELECT_REG=1 -> 0,0,0,0,0,0,1,1. SELECT_REG=6 -> 0,0,0,1,0,1,0,0.
3. AUTO_INC=1, SELECT_REG=5 -> 16 contiguous bits covering bytes 5 then 6; BYTE_DONE at n+8 and n+16; FRAME_DONE at n+16; BUSY low from n+16.
4. SELECT_REG=7 at trigger -> SEL_ERR is a one-cycle pulse; BUSY stays 0; CNT_SER stays 0.
5. Change CNT and toggle INST_READOUT during SHIFT -> serialized bits still match the original snapshot; no retrigger occurs.
6. Assert RST at cycle n+4 -> all outputs 0 immediately, no BYTE_DONE. After deassertion, a fresh trigger shifts the correct byte. With CH_READOUT_PARITY_EN, case 1 adds a parity bit 0 at n+9, with BYTE_DONE at n+9.
